serial_tx: RTL and testbench



---
 rtl/serial_tx_pkg.sv | 14 +
 rtl/serial_tx_if.sv | 26 ++
 rtl/serial_tx.sv | 121 ++++++++++++
 tb/tb_serial_tx.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types for the serial_tx serializer: FSM state encoding and
// shift-direction constants.
package serial_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/serial_tx_if.sv
// Word-in handshake plus serial-load strobes toward a shift register.
// The master side issues words; the slave side (serial_tx) drives the serial pairs.
interface serial_tx_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] in;
   logic             start;
   logic             dir;
   logic             abort;
   logic             ready;
   logic             sr;
   logic             ir;
   logic             sl;
   logic             il;
   logic             done;

   modport master (
      output in, start, dir, abort,
      input  ready, sr, ir, sl, il, done
   );

   modport slave (
      input  in, start, dir, abort,
      output ready, sr, ir, sl, il, done
   );
endinterface

// File: rtl/serial_tx.sv
// Serializes one WIDTH-bit word onto the shift-right or shift-left serial pair
// of a downstream register so the receiver holds the original word after WIDTH shifts.
module serial_tx
   import serial_tx_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   serial_tx_if.slave   bus
);

   localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shbuf_q, shbuf_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic             dir_q,   dir_d;
   logic             ready_q, ready_d;
   logic             sr_q,    sr_d;
   logic             ir_q,    ir_d;
   logic             sl_q,    sl_d;
   logic             il_q,    il_d;
   logic             done_q,  done_d;

   // Word/direction whose next bit is presented in the coming cycle.
   logic             tx_en;
   logic [WIDTH-1:0] tx_word;
   logic             tx_dir;

   always_comb begin
      state_d = state_q;
      shbuf_d = shbuf_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      ready_d = 1'b0;
      done_d  = 1'b0;
      tx_en   = 1'b0;
      tx_word = shbuf_q;
      tx_dir  = dir_q;

      unique case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (bus.start) begin
               shbuf_d = bus.in;
               dir_d   = bus.dir;
               cnt_d   = '0;
               state_d = SHIFT;
               ready_d = 1'b0;
               tx_en   = 1'b1;
               tx_word = bus.in;
               tx_dir  = bus.dir;
            end
         end
         SHIFT: begin
            if (bus.abort) begin
               state_d = IDLE;
               ready_d = 1'b1;
            end else if (cnt_q == LAST) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               // Counter stops at LAST, so it never wraps mid-transfer.
               cnt_d   = cnt_q + 1'b1;
               shbuf_d = (dir_q == DIR_LEFT) ? (shbuf_q << 1) : (shbuf_q >> 1);
               tx_en   = 1'b1;
               tx_word = shbuf_d;
            end
         end
         DONE: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase

      sr_d = tx_en && (tx_dir == DIR_RIGHT);
      sl_d = tx_en && (tx_dir == DIR_LEFT);
      ir_d = sr_d && tx_word[0];
      il_d = sl_d && tx_word[WIDTH-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shbuf_q <= '0;
         cnt_q   <= '0;
         dir_q   <= DIR_RIGHT;
         ready_q <= 1'b1;
         sr_q    <= 1'b0;
         ir_q    <= 1'b0;
         sl_q    <= 1'b0;
         il_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shbuf_q <= shbuf_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         ready_q <= ready_d;
         sr_q    <= sr_d;
         ir_q    <= ir_d;
         sl_q    <= sl_d;
         il_q    <= il_d;
         done_q  <= done_d;
      end
   end

   assign bus.ready = ready_q;
   assign bus.sr    = sr_q;
   assign bus.ir    = ir_q;
   assign bus.sl    = sl_q;
   assign bus.il    = il_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboarded bench for serial_tx driving a 4-bit serial-load receiver register.
module tb_serial_tx;
   import serial_tx_pkg::*;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_tx_if #(.WIDTH(W)) bus ();
   serial_tx #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   // Receiver: 4-bit register with clear/load/inc/dec tied off, serial pairs wired.
   logic         cl = 1'b0, ld = 1'b0, inc = 1'b0, dec = 1'b0;
   logic [W-1:0] ld_data = '0;
   logic [W-1:0] rx;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        rx <= '0;
      else if (cl)       rx <= '0;
      else if (ld)       rx <= ld_data;
      else if (inc)      rx <= rx + 1'b1;
      else if (dec)      rx <= rx - 1'b1;
      else if (bus.sr)   rx <= {bus.ir, rx[W-1:1]};
      else if (bus.sl)   rx <= {rx[W-2:0], bus.il};
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ndone = 0;
   logic [3:0]   bit_q[$];   // expected {sr,sl,ir,il} per shift cycle
   logic [W-1:0] word_q[$];  // expected receiver word at each done
   int           done_cyc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic push_xfer(input logic [W-1:0] w, input logic d, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         logic b;
         b = (d == DIR_LEFT) ? w[W-1-i] : w[i];
         bit_q.push_back((d == DIR_LEFT) ? {3'b010, b} : {2'b10, b, 1'b0});
      end
      if (nbits == W) word_q.push_back(w);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.ready) break;
      end
      chk("wait_ready", {31'd0, bus.ready}, 1);
   endtask

   // Returns #1 after the accepting edge E0.
   task automatic send(input logic [W-1:0] w, input logic d, input int nbits);
      wait_ready();
      push_xfer(w, d, nbits);
      bus.start = 1'b1;
      bus.in    = w;
      bus.dir   = d;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.in    = W'($urandom);
      bus.dir   = 1'($urandom);
   endtask

   task automatic wait_done(output int dc);
      int n0;
      n0 = ndone;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (ndone > n0) break;
      end
      chk("done_seen", {31'd0, ndone > n0}, 1);
      dc = (done_cyc_q.size() > 0) ? done_cyc_q[$] : 0;
   endtask

   // Monitor: every strobe and every done pulse is checked against the queues.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.sr || bus.sl) begin
            if (bit_q.size() == 0) begin
               total++; bad++;
               $display("FAIL stray_strobe: sr=%b sl=%b with none expected", bus.sr, bus.sl);
            end else begin
               chk("serial_bit", {28'd0, bus.sr, bus.sl, bus.ir, bus.il}, {28'd0, bit_q.pop_front()});
            end
         end
         if (bus.done) begin
            ndone++;
            done_cyc_q.push_back(cyc);
            if (word_q.size() == 0) begin
               total++; bad++;
               $display("FAIL stray_done: done=1 with no transfer expected, rx=%0h", rx);
            end else begin
               chk("rx_word", {28'd0, rx}, {28'd0, word_q.pop_front()});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, dc, nd;
      bus.start = 1'b0;
      bus.in    = '0;
      bus.dir   = 1'b0;
      bus.abort = 1'b0;

      #12;
      chk("reset_outs", {26'd0, bus.ready, bus.sr, bus.ir, bus.sl, bus.il, bus.done}, 6'b100000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, bus.ready}, 1);

      // Right shift 1011: ir = 1,1,0,1; done one cycle after E4.
      send(4'b1011, DIR_RIGHT, 4);
      t0 = cyc;
      wait_done(dc);
      chk("latency_done", dc - t0, 4);
      chk("ready_in_done", {31'd0, bus.ready}, 0);
      @(negedge clk);
      chk("ready_after_done", {31'd0, bus.ready}, 1);
      chk("done_one_cycle", {31'd0, bus.done}, 0);

      // Left shift 0110: il = 0,1,1,0 on sl; sr/ir stay 0 (checked per bit).
      send(4'h6, DIR_LEFT, 4);
      wait_done(dc);

      // start held high, A then 5: second word waits for ready, 6-cycle spacing.
      wait_ready();
      push_xfer(4'hA, DIR_RIGHT, 4);
      bus.start = 1'b1;
      bus.in    = 4'hA;
      bus.dir   = DIR_RIGHT;
      @(posedge clk);
      #1;
      bus.in = 4'h5;
      push_xfer(4'h5, DIR_RIGHT, 4);
      wait_ready();
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(dc);
      chk("b2b_count", done_cyc_q.size(), 4);
      if (done_cyc_q.size() >= 2)
         chk("b2b_spacing", done_cyc_q[$] - done_cyc_q[$-1], 6);

      // Abort during the 2nd shift cycle: only two bits go out, no done.
      send(4'hC, DIR_RIGHT, 2);
      @(posedge clk);
      #1;
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      chk("abort_outs", {27'd0, bus.sr, bus.sl, bus.done, bus.ready, 1'b0}, 5'b00010);
      nd = ndone;
      repeat (6) @(negedge clk);
      chk("abort_no_done", ndone, nd);
      send(4'h3, DIR_LEFT, 4);
      wait_done(dc);

      // Reset mid-shift: outputs return to reset values without a clock edge.
      send(4'h9, DIR_LEFT, 1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_outs", {26'd0, bus.ready, bus.sr, bus.ir, bus.sl, bus.il, bus.done}, 6'b100000);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ready_after_midreset", {31'd0, bus.ready}, 1);
      send(4'h5, DIR_RIGHT, 4);
      wait_done(dc);

      // start+abort together in IDLE: start wins; a later busy start is ignored.
      wait_ready();
      push_xfer(4'hE, DIR_RIGHT, 4);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      bus.in    = 4'hE;
      bus.dir   = DIR_RIGHT;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("start_beats_abort", {31'd0, bus.sr}, 1);
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.in    = 4'h1;
      bus.dir   = DIR_LEFT;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(dc);

      repeat (3) @(negedge clk);
      chk("queues_drained", bit_q.size() + word_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
